// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 16-bit pipelined core.
// Captures decoded operands and control from decode and presents them to EX
// (ALU and RED reduction unit). Supports stall (hold) and flush (bubble).
// Edge priority: reset > flush > stall > load.
// Optional feature macro: ID_EX_FWD_EN -- when defined, the EX operands are
// muxed with the EX/MEM and MEM/WB forwarding paths; when undefined the
// forwarding ports are present but ignored.
module id_ex_pipe_reg #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [OP_W-1:0]   id_opcode,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_wr,
   input  logic              id_mem_rd,
   input  logic              id_mem_wr,
   input  logic              id_halt,
   input  logic [1:0]        fwd_a_sel,
   input  logic [1:0]        fwd_b_sel,
   input  logic [DATA_W-1:0] exmem_fwd_data,
   input  logic [DATA_W-1:0] memwb_fwd_data,
   output logic              ex_valid,
   output logic [OP_W-1:0]   ex_opcode,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_wr,
   output logic              ex_mem_rd,
   output logic              ex_mem_wr,
   output logic              ex_halt,
   output logic              ex_is_red
);

   localparam logic [OP_W-1:0] OP_RED = OP_W'(3);

   logic              valid_q,  valid_d;
   logic [OP_W-1:0]   opcode_q, opcode_d;
   logic [DATA_W-1:0] rs_q,     rs_d;
   logic [DATA_W-1:0] rt_q,     rt_d;
   logic [DATA_W-1:0] imm_q,    imm_d;
   logic [REG_AW-1:0] rd_q,     rd_d;
   logic              reg_wr_q, reg_wr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic              halt_q,   halt_d;

   // Next-state selection: flush inserts an all-zero bubble, stall holds, else load.
   always_comb begin
      valid_d  = valid_q;
      opcode_d = opcode_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      imm_d    = imm_q;
      rd_d     = rd_q;
      reg_wr_d = reg_wr_q;
      mem_rd_d = mem_rd_q;
      mem_wr_d = mem_wr_q;
      halt_d   = halt_q;
      if (flush) begin
         valid_d  = 1'b0;
         opcode_d = '0;
         rs_d     = '0;
         rt_d     = '0;
         imm_d    = '0;
         rd_d     = '0;
         reg_wr_d = 1'b0;
         mem_rd_d = 1'b0;
         mem_wr_d = 1'b0;
         halt_d   = 1'b0;
      end else if (!stall) begin
         valid_d  = id_valid;
         opcode_d = id_opcode;
         rs_d     = id_rs_data;
         rt_d     = id_rt_data;
         imm_d    = id_imm;
         rd_d     = id_rd;
         reg_wr_d = id_reg_wr;
         mem_rd_d = id_mem_rd;
         mem_wr_d = id_mem_wr;
         halt_d   = id_halt;
      end
   end

   // Register update; synchronous reset overrides flush, stall and load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         opcode_q <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         imm_q    <= '0;
         rd_q     <= '0;
         reg_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         halt_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         opcode_q <= opcode_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         imm_q    <= imm_d;
         rd_q     <= rd_d;
         reg_wr_q <= reg_wr_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         halt_q   <= halt_d;
      end
   end

`ifdef ID_EX_FWD_EN
   // Operand muxes: forwarded results bypass the latched operands with no added latency.
   always_comb begin
      ex_op_a = rs_q;
      ex_op_b = rt_q;
      case (fwd_a_sel)
         2'b01:   ex_op_a = exmem_fwd_data;
         2'b10:   ex_op_a = memwb_fwd_data;
         default: ex_op_a = rs_q;
      endcase
      case (fwd_b_sel)
         2'b01:   ex_op_b = exmem_fwd_data;
         2'b10:   ex_op_b = memwb_fwd_data;
         default: ex_op_b = rt_q;
      endcase
   end
`else
   // Operands come straight from the latched register-file reads; forwarding inputs are ignored.
   logic unused_fwd;
   assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, exmem_fwd_data, memwb_fwd_data};

   always_comb begin
      ex_op_a = rs_q;
      ex_op_b = rt_q;
   end
`endif

   // Control outputs are qualified by valid so a bubble has no side effects.
   assign ex_valid  = valid_q;
   assign ex_opcode = opcode_q;
   assign ex_imm    = imm_q;
   assign ex_rd     = rd_q;
   assign ex_reg_wr = valid_q & reg_wr_q;
   assign ex_mem_rd = valid_q & mem_rd_q;
   assign ex_mem_wr = valid_q & mem_wr_q;
   assign ex_halt   = valid_q & halt_q;
   assign ex_is_red = valid_q & (opcode_q == OP_RED);

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, stall, flush, gating,
// operand forwarding (build-dependent on ID_EX_FWD_EN) and halt behaviour.
module tb_id_ex_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [15:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_rd;
   logic        id_reg_wr, id_mem_rd, id_mem_wr, id_halt;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] exmem_fwd_data, memwb_fwd_data;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_op_a, ex_op_b, ex_imm;
   logic [3:0]  ex_rd;
   logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt, ex_is_red;

   int n_checks = 0;
   int n_errors = 0;

   // Clock and reset
   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
      .id_mem_wr(id_mem_wr), .id_halt(id_halt),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_op_a(ex_op_a),
      .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_halt(ex_halt), .ex_is_red(ex_is_red)
   );

   // Scoreboard check
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Driver: present one decoded instruction on the id_* inputs
   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] rs,
                        input logic [15:0] rt, input logic [15:0] imm, input logic [3:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic h);
      id_valid   = v;
      id_opcode  = op;
      id_rs_data = rs;
      id_rt_data = rt;
      id_imm     = imm;
      id_rd      = rd;
      id_reg_wr  = rw;
      id_mem_rd  = mr;
      id_mem_wr  = mw;
      id_halt    = h;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"},  32'(ex_valid),  32'h0);
      check({tag, ".opcode"}, 32'(ex_opcode), 32'h0);
      check({tag, ".op_a"},   32'(ex_op_a),   32'h0);
      check({tag, ".op_b"},   32'(ex_op_b),   32'h0);
      check({tag, ".imm"},    32'(ex_imm),    32'h0);
      check({tag, ".rd"},     32'(ex_rd),     32'h0);
      check({tag, ".reg_wr"}, 32'(ex_reg_wr), 32'h0);
      check({tag, ".mem_rd"}, 32'(ex_mem_rd), 32'h0);
      check({tag, ".mem_wr"}, 32'(ex_mem_wr), 32'h0);
      check({tag, ".halt"},   32'(ex_halt),   32'h0);
      check({tag, ".is_red"}, 32'(ex_is_red), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
      exmem_fwd_data = 16'h0; memwb_fwd_data = 16'h0;
      drive(1'b1, 4'h7, 16'hDEAD, 16'hBEEF, 16'h1111, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      #2;

      // 1. reset for one edge, then RED instruction
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      drive(1'b1, 4'h3, 16'h1234, 16'h00FF, 16'h0042, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("t1.op_a",   32'(ex_op_a),   32'h1234);
      check("t1.op_b",   32'(ex_op_b),   32'h00FF);
      check("t1.is_red", 32'(ex_is_red), 32'h1);
      check("t1.valid",  32'(ex_valid),  32'h1);
      check("t1.imm",    32'(ex_imm),    32'h0042);
      check("t1.rd",     32'(ex_rd),     32'h2);
      check("t1.reg_wr", 32'(ex_reg_wr), 32'h1);
      check("t1.mem_rd", 32'(ex_mem_rd), 32'h0);

      // 2. load X then hold for three stalled cycles with changing inputs
      drive(1'b1, 4'h1, 16'h1111, 16'h2222, 16'h0007, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check("t2.load.rd", 32'(ex_rd),     32'h5);
      check("t2.load.is_red", 32'(ex_is_red), 32'h0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(i + 8), 16'h9990 + 16'(i), 16'h8880, 16'h0FF0, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1);
         step();
         check("t2.hold.rd",     32'(ex_rd),     32'h5);
         check("t2.hold.opcode", 32'(ex_opcode), 32'h1);
         check("t2.hold.op_a",   32'(ex_op_a),   32'h1111);
         check("t2.hold.op_b",   32'(ex_op_b),   32'h2222);
         check("t2.hold.imm",    32'(ex_imm),    32'h0007);
         check("t2.hold.reg_wr", 32'(ex_reg_wr), 32'h1);
         check("t2.hold.mem_wr", 32'(ex_mem_wr), 32'h0);
         check("t2.hold.halt",   32'(ex_halt),   32'h0);
      end

      // 3. flush wins over stall
      flush = 1'b1;
      step();
      check_all_zero("t3.flush");
      flush = 1'b0;
      stall = 1'b0;

      // Invalid slot: control bits latched but gated off, data still latched
      drive(1'b0, 4'h3, 16'h4321, 16'h8765, 16'h0003, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      check("gate.valid",  32'(ex_valid),  32'h0);
      check("gate.reg_wr", 32'(ex_reg_wr), 32'h0);
      check("gate.mem_rd", 32'(ex_mem_rd), 32'h0);
      check("gate.mem_wr", 32'(ex_mem_wr), 32'h0);
      check("gate.halt",   32'(ex_halt),   32'h0);
      check("gate.is_red", 32'(ex_is_red), 32'h0);
      check("gate.opcode", 32'(ex_opcode), 32'h3);
      check("gate.op_a",   32'(ex_op_a),   32'h4321);

      // Valid load with memory read and write control
      drive(1'b1, 4'h2, 16'h0A0A, 16'h0B0B, 16'h0010, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      check("mem.mem_rd", 32'(ex_mem_rd), 32'h1);
      check("mem.mem_wr", 32'(ex_mem_wr), 32'h1);
      check("mem.reg_wr", 32'(ex_reg_wr), 32'h0);

      // 4/5. forwarding muxes, evaluated combinationally in the same cycle
      drive(1'b1, 4'h0, 16'h0001, 16'h0002, 16'h0000, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      exmem_fwd_data = 16'hAAAA;
      memwb_fwd_data = 16'h5555;
      for (int s = 0; s < 4; s++) begin
         logic [15:0] exp_a, exp_b;
         fwd_a_sel = 2'(s);
         fwd_b_sel = 2'(3 - s);
`ifdef ID_EX_FWD_EN
         exp_a = (s == 1) ? 16'hAAAA : (s == 2) ? 16'h5555 : 16'h0001;
         exp_b = ((3 - s) == 1) ? 16'hAAAA : ((3 - s) == 2) ? 16'h5555 : 16'h0002;
`else
         exp_a = 16'h0001;
         exp_b = 16'h0002;
`endif
         #1;
         check($sformatf("fwd.a.sel%0d", s), 32'(ex_op_a), 32'(exp_a));
         check($sformatf("fwd.b.sel%0d", 3 - s), 32'(ex_op_b), 32'(exp_b));
      end
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;

      // 6. halt lasts one cycle, then flush clears it
      drive(1'b1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("halt.set", 32'(ex_halt), 32'h1);
      flush = 1'b1;
      step();
      check("halt.flush", 32'(ex_halt), 32'h0);
      flush = 1'b0;
      drive(1'b1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("halt.set2", 32'(ex_halt), 32'h1);
      drive(1'b1, 4'h1, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      check("halt.newinstr", 32'(ex_halt), 32'h0);

      // Reset asserted mid-stall overrides held contents
      drive(1'b1, 4'h3, 16'hCAFE, 16'hF00D, 16'h00AB, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      check("prestall.is_red", 32'(ex_is_red), 32'h1);
      stall = 1'b1;
      step();
      check("stall.op_a", 32'(ex_op_a), 32'hCAFE);
      rst_n = 1'b0;
      step();
      check_all_zero("rst_in_stall");
      rst_n = 1'b1;
      stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
